// File: rtl/servo_bank_controller.sv
// N-channel hobby-servo controller: clamps and slews the selected channel's command once per
// frame, and generates every channel's PWM output from one shared frame counter.
module servo_bank_controller #(
    parameter int NUM_SERVOS = 4,
    parameter int CLK_HZ     = 25_000_000,
    parameter int FRAME_US   = 20000,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 2500,
    parameter int CENTER_US  = 1500,
    parameter int STEP_US    = 20,
    parameter int CMD_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_SERVOS-1:0] sel_btn,
    input  logic [CMD_W-1:0]      target_us,
    input  logic                  target_valid,
    output logic [NUM_SERVOS-1:0] pwm,
    output logic [NUM_SERVOS-1:0] sel_onehot,
    output logic [CMD_W-1:0]      active_cmd,
    output logic                  busy
);

    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int SEL_W  = $clog2(NUM_SERVOS);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(US_DIV - 1);
    localparam logic [CMD_W-1:0] FRAME_LAST = CMD_W'(FRAME_US - 1);
    localparam logic [CMD_W-1:0] MIN_V      = CMD_W'(MIN_US);
    localparam logic [CMD_W-1:0] MAX_V      = CMD_W'(MAX_US);
    localparam logic [CMD_W-1:0] CENTER_V   = CMD_W'(CENTER_US);
    localparam logic [CMD_W:0]   STEP_V     = (CMD_W + 1)'(STEP_US);

    logic [PRE_W-1:0]      prescaler;
    logic [CMD_W-1:0]      frame_cnt;
    logic                  us_tick;
    logic                  frame_end;

    logic [SEL_W-1:0]      sel;
    logic [SEL_W-1:0]      new_sel;
    logic [NUM_SERVOS-1:0] btn_prev;
    logic [NUM_SERVOS-1:0] rise;
    logic                  sel_change;

    logic [CMD_W-1:0]      target_reg;
    logic [CMD_W-1:0]      clamped;
    logic [CMD_W-1:0]      cmd    [NUM_SERVOS];
    logic [CMD_W-1:0]      shadow [NUM_SERVOS];

    logic [CMD_W:0]        cur_w;
    logic [CMD_W:0]        tgt_w;
    logic [CMD_W:0]        slew_w;
    logic [CMD_W-1:0]      slew_next;

    assign us_tick   = (prescaler == PRE_LAST);
    assign frame_end = us_tick && (frame_cnt == FRAME_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler <= '0;
            frame_cnt <= '0;
        end else if (us_tick) begin
            prescaler <= '0;
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Descending scan so the lowest-index rising edge is the one that sticks.
    always_comb begin
        rise    = sel_btn & ~btn_prev;
        new_sel = '0;
        for (int i = NUM_SERVOS - 1; i >= 0; i--) begin
            if (rise[i]) new_sel = SEL_W'(i);
        end
    end

    assign sel_change = |rise;

    always_comb begin
        if (target_us < MIN_V)      clamped = MIN_V;
        else if (target_us > MAX_V) clamped = MAX_V;
        else                        clamped = target_us;
    end

    // Differences are taken before stepping so the result can neither wrap nor overshoot.
    always_comb begin
        cur_w = {1'b0, cmd[sel]};
        tgt_w = {1'b0, target_reg};
        if (cur_w < tgt_w) begin
            slew_w = (tgt_w - cur_w <= STEP_V) ? tgt_w : cur_w + STEP_V;
        end else if (cur_w > tgt_w) begin
            slew_w = (cur_w - tgt_w <= STEP_V) ? tgt_w : cur_w - STEP_V;
        end else begin
            slew_w = cur_w;
        end
        slew_next = slew_w[CMD_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel        <= '0;
            btn_prev   <= '0;
            target_reg <= CENTER_V;
        end else begin
            btn_prev <= sel_btn;
            if (sel_change) begin
                sel        <= new_sel;
                target_reg <= cmd[new_sel];
            end else if (target_valid) begin
                target_reg <= clamped;
            end
        end
    end

    // Shadows latch the pre-slew command so pulse widths only change on frame boundaries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                cmd[i]    <= CENTER_V;
                shadow[i] <= CENTER_V;
            end
            pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                pwm[i] <= (frame_cnt < shadow[i]);
            end
            if (frame_end) begin
                for (int i = 0; i < NUM_SERVOS; i++) begin
                    shadow[i] <= cmd[i];
                end
                cmd[sel] <= slew_next;
            end
        end
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign active_cmd = cmd[sel];
    assign busy       = (cmd[sel] != target_reg);

endmodule

// File: tb/tb_servo_bank_controller.sv
// Bench for servo_bank_controller: a per-cycle reference model driven from cycle counts, a
// table of clamp/ramp vectors, hand-written selection/reset sequences and a random phase.
module tb_servo_bank_controller;

    localparam int NS        = 4;
    localparam int DIV       = 2;
    localparam int FR        = 200;
    localparam int MINU      = 20;
    localparam int MAXU      = 180;
    localparam int CEN       = 100;
    localparam int STEP      = 10;
    localparam int FRAME_CYC = DIV * FR;

    logic        CLK          = 1'b0;
    logic        RST          = 1'b1;
    logic [3:0]  sel_btn      = '0;
    logic [15:0] target_us    = '0;
    logic        target_valid = 1'b0;
    logic [3:0]  pwm;
    logic [3:0]  sel_onehot;
    logic [15:0] active_cmd;
    logic        busy;

    servo_bank_controller #(
        .NUM_SERVOS(NS), .CLK_HZ(2_000_000), .FRAME_US(FR), .MIN_US(MINU),
        .MAX_US(MAXU), .CENTER_US(CEN), .STEP_US(STEP), .CMD_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .sel_btn(sel_btn), .target_us(target_us),
        .target_valid(target_valid), .pwm(pwm), .sel_onehot(sel_onehot),
        .active_cmd(active_cmd), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    int         m_sel, m_tgt, m_cyc;
    int         m_cmd    [4];
    int         m_shadow [4];
    logic [3:0] m_prev, m_pwm;

    typedef struct {
        logic [15:0] tu;
        int          exp_cmd;
        int          exp_frames;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s @%0t: wait timed out", name, $time);
    endtask

    function automatic int clampRef(input int v);
        if (v < MINU) return MINU;
        if (v > MAXU) return MAXU;
        return v;
    endfunction

    // Behaviour worked out from the cycle count since reset and the slew/selection rules.
    task automatic modelUpdate();
        int         fc;
        bit         fend;
        logic [3:0] rise;
        int         ns, os, ot;
        int         oc [4];
        if (RST) begin
            m_sel = 0; m_tgt = CEN; m_prev = '0; m_cyc = 0; m_pwm = '0;
            for (int i = 0; i < NS; i++) begin
                m_cmd[i] = CEN;
                m_shadow[i] = CEN;
            end
            return;
        end
        fc   = (m_cyc / DIV) % FR;
        fend = (m_cyc % FRAME_CYC) == FRAME_CYC - 1;
        for (int i = 0; i < NS; i++) m_pwm[i] = (fc < m_shadow[i]);
        os = m_sel;
        ot = m_tgt;
        oc = m_cmd;
        if (fend) begin
            m_shadow = oc;
            if (oc[os] < ot)      m_cmd[os] = (oc[os] + STEP > ot) ? ot : oc[os] + STEP;
            else if (oc[os] > ot) m_cmd[os] = (oc[os] - STEP < ot) ? ot : oc[os] - STEP;
        end
        rise = sel_btn & ~m_prev;
        if (rise != 4'b0000) begin
            ns = 0;
            while (!rise[ns]) ns++;
            m_sel = ns;
            m_tgt = oc[ns];
        end else if (target_valid) begin
            m_tgt = clampRef(int'(target_us));
        end
        m_prev = sel_btn;
        m_cyc++;
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] btn, input logic [15:0] tu, input logic tv);
        RST          = rst;
        sel_btn      = btn;
        target_us    = tu;
        target_valid = tv;
        @(posedge CLK);
        modelUpdate();
        @(negedge CLK);
        checkOutput("cycle", {pwm, sel_onehot, active_cmd, busy},
                    {m_pwm, 4'(1 << m_sel), 16'(m_cmd[m_sel]), 1'(m_cmd[m_sel] != m_tgt)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, sel_btn, 16'd0, 1'b0);
    endtask

    task automatic waitChange(input string nm, input int budget);
        logic [15:0] p;
        int          n;
        p = active_cmd;
        n = 0;
        while (active_cmd == p && n < budget) begin
            idle(1);
            n++;
        end
        if (active_cmd == p) reportTimeout(nm);
    endtask

    initial begin
        int hi0, hi1, hi3, n, frames;
        logic [15:0] p;
        logic [3:0]  btn;
        logic [15:0] tu;
        logic        tv;

        vecs[0] = '{16'd0,     20,  13};
        vecs[1] = '{16'hFFFF,  180, 16};
        vecs[2] = '{16'd25,    25,  16};
        vecs[3] = '{16'd5,     20,  1};
        vecs[4] = '{16'd1000,  180, 16};
        vecs[5] = '{16'd150,   150, 3};

        repeat (3) applyStimulus(1'b1, 4'b0000, 16'd0, 1'b0);
        checkOutput("reset_onehot", sel_onehot, 4'b0001);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pwm", pwm, 0);
        hi0 = 0; hi3 = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            applyStimulus(1'b0, 4'b0000, 16'd0, 1'b0);
            hi0 += pwm[0];
            hi3 += pwm[3];
            if (k == 199) checkOutput("first_pulse_last_high", pwm, 4'hF);
            if (k == 200) checkOutput("first_pulse_fall", pwm, 4'h0);
        end
        checkOutput("reset_high_time_ch0", hi0, 200);
        checkOutput("reset_high_time_ch3", hi3, 200);

        applyStimulus(1'b0, 4'b0000, 16'd150, 1'b1);
        checkOutput("ramp_busy", busy, 1);
        for (int s = 1; s <= 5; s++) begin
            waitChange("ramp_step", 2 * FRAME_CYC);
            checkOutput("ramp_cmd", active_cmd, 100 + 10 * s);
        end
        checkOutput("ramp_done_busy", busy, 0);
        hi0 = 0; hi1 = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            idle(1);
            hi0 += pwm[0];
            hi1 += pwm[1];
        end
        checkOutput("lag_frame_ch0", hi0, 280);
        checkOutput("idle_channel_ch1", hi1, 200);
        hi0 = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            idle(1);
            hi0 += pwm[0];
        end
        checkOutput("settled_frame_ch0", hi0, 300);

        foreach (vecs[v]) begin
            applyStimulus(1'b0, 4'b0000, vecs[v].tu, 1'b1);
            checkOutput("vec_busy", busy, 1);
            frames = 0; n = 0;
            while (busy && n < (vecs[v].exp_frames + 2) * FRAME_CYC) begin
                p = active_cmd;
                idle(1);
                if (active_cmd != p) frames++;
                n++;
            end
            if (busy) reportTimeout("vec_settle");
            checkOutput("vec_cmd", active_cmd, vecs[v].exp_cmd);
            checkOutput("vec_frames", frames, vecs[v].exp_frames);
        end

        applyStimulus(1'b0, 4'b0000, 16'd20, 1'b1);
        waitChange("sel_ramp1", 2 * FRAME_CYC);
        waitChange("sel_ramp2", 2 * FRAME_CYC);
        idle(100);
        applyStimulus(1'b0, 4'b0100, 16'd0, 1'b0);
        checkOutput("sel2_onehot", sel_onehot, 4'b0100);
        checkOutput("sel2_busy", busy, 0);
        checkOutput("sel2_cmd", active_cmd, 100);
        idle(1200);
        applyStimulus(1'b0, 4'b0000, 16'd0, 1'b0);
        applyStimulus(1'b0, 4'b1010, 16'd0, 1'b0);
        checkOutput("sel_lowest_wins", sel_onehot, 4'b0010);
        checkOutput("sel1_cmd", active_cmd, 100);

        applyStimulus(1'b0, 4'b0000, 16'd0, 1'b0);
        applyStimulus(1'b0, 4'b1000, 16'd50, 1'b1);
        checkOutput("collision_onehot", sel_onehot, 4'b1000);
        checkOutput("collision_busy", busy, 0);
        idle(900);
        checkOutput("collision_no_ramp", active_cmd, 100);

        applyStimulus(1'b0, 4'b0000, 16'd0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 16'd0, 1'b0);
        checkOutput("ch0_frozen", active_cmd, 130);
        applyStimulus(1'b0, 4'b0001, 16'd150, 1'b1);
        n = 0;
        while (busy && n < 4 * FRAME_CYC) begin idle(1); n++; end
        if (busy) reportTimeout("ch0_to_150");
        checkOutput("ch0_at_150", active_cmd, 150);
        idle(FRAME_CYC + 10);
        n = 0;
        while (!pwm[0] && n < 2 * FRAME_CYC) begin idle(1); n++; end
        if (!pwm[0]) reportTimeout("wait_pwm_high");
        applyStimulus(1'b1, 4'b0000, 16'd0, 1'b0);
        checkOutput("midpulse_reset_pwm", pwm, 4'h0);
        hi0 = 0; hi3 = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            applyStimulus(1'b0, 4'b0000, 16'd0, 1'b0);
            hi0 += pwm[0];
            hi3 += pwm[3];
        end
        checkOutput("post_reset_ch0", hi0, 200);
        checkOutput("post_reset_ch3", hi3, 200);

        for (int i = 0; i < 15000; i++) begin
            btn = sel_btn;
            if ($urandom_range(0, 299) == 0) btn = 4'($urandom_range(0, 15));
            tv = ($urandom_range(0, 49) == 0);
            tu = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            applyStimulus(1'b0, btn, tu, tv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/servo_bank_controller.md
# servo_bank_controller

Parametrised N-channel hobby-servo controller that replaces the fixed four-servo top-level logic. It takes a microsecond target for the currently selected channel, clamps it, and slews that channel's command toward it at a bounded rate once per servo frame. It generates all N PWM outputs from one shared frame counter. It sits between the joystick/scaling front end and the PMOD servo pins; non-selected channels hold their last command.

## Interface

**Parameters**
- `NUM_SERVOS`, default 4: number of channels (2..16).
- `CLK_HZ`, default 25_000_000: CLK frequency. `US_DIV = CLK_HZ/1_000_000` (integer, ≥1).
- `FRAME_US`, default 20000: PWM period in µs.
- `MIN_US`, default 500: lowest legal pulse width.
- `MAX_US`, default 2500: highest legal pulse width.
- `CENTER_US`, default 1500: reset pulse width for every channel.
- `STEP_US`, default 20: maximum command change per frame (must be >0).
- `CMD_W`, default 16: width of µs quantities. Must hold `FRAME_US`.

**Ports**
- `CLK`, in, 1: system clock.
- `RST`, in, 1: synchronous, active-high reset.
- `sel_btn`, in, NUM_SERVOS: channel-select buttons, one per channel. Already synchronised.
- `target_us`, in, CMD_W: requested pulse width for the selected channel. Unsigned.
- `target_valid`, in, 1: one-cycle strobe; `target_us` is sampled on this cycle.
- `pwm`, out, NUM_SERVOS: servo signals.
- `sel_onehot`, out, NUM_SERVOS: selected channel, drives LEDs.
- `active_cmd`, out, CMD_W: current command of the selected channel.
- `busy`, out, 1: selected channel's command ≠ its target.

## Operation

**Selection**
- `btn_prev` register per channel. A rising edge (`!prev && btn`) on channel i selects i.
- Simultaneous rising edges: the lowest index wins.
- On a selection change, `target_reg` is loaded with the newly selected channel's current `cmd`. There is no jump until the next `target_valid`.
- If `target_valid` arrives on the same cycle as a selection change, the selection load wins and `target_valid` is dropped.

**Target capture**
- On `target_valid`, `target_reg <= clamp(target_us, MIN_US, MAX_US)`.

**Timebase**
- Prescaler counts 0..US_DIV-1. `us_tick` is asserted when the prescaler equals US_DIV-1.
- `frame_cnt` counts 0..FRAME_US-1 and advances on `us_tick`.
- `frame_end` = `us_tick && frame_cnt == FRAME_US-1`.

**Slew (on `frame_end` only, selected channel only)**
- If `cmd < target_reg`: `cmd <= min(cmd + STEP_US, target_reg)`.
- If `cmd > target_reg`: `cmd <= max(cmd - STEP_US, target_reg)`.
- If equal: hold.
- All arithmetic is done in CMD_W+1 bits, with no wrap.
- Non-selected channels never change.

**Shadowing and PWM**
- On `frame_end`, `shadow[i] <= cmd[i]`, using the pre-slew value. A slewed command is therefore first emitted one frame after it is computed.
- `pwm[i]` is registered: `pwm[i] <= (frame_cnt < shadow[i])`.
- Pulse widths never change mid-frame.

**Outputs**
- `active_cmd` = `cmd[sel]`.
- `busy` = (`cmd[sel]` ≠ `target_reg`).

## Timing

**Reset values (cycle after `RST` is sampled high)**
- `sel` = 0, so `sel_onehot` = 1.
- All `cmd` and all `shadow` = CENTER_US.
- `target_reg` = CENTER_US.
- Prescaler and `frame_cnt` = 0.
- `pwm` = all 0.
- `busy` = 0.
- `btn_prev` = 0.
- Reset mid-pulse forces `pwm` low on the next edge.

**After reset release**
- The first `pwm` rise is 1 cycle after release, since `frame_cnt = 0 < CENTER_US`.

**Latencies**
- `sel_btn` edge → `sel_onehot` update: 1 cycle after the rising edge is sampled.
- `target_valid` → `busy`: 1 cycle.
- `target_valid` → first changed pulse: the first `frame_end` slews `cmd`; the pulse appears in the frame after the next `frame_end`.

**Ramp timing**
- A full swing ΔUS needs ceil(ΔUS/STEP_US) frames.
- `busy` deasserts 1 cycle after the `frame_end` that reaches the target.

**Boundaries**
- `target_us` = 0 → MIN_US.
- `target_us` = 0xFFFF → MAX_US.
- If `cmd` is within STEP_US of the target, it lands exactly on the target with no overshoot.
- `frame_cnt` wraps FRAME_US-1 → 0 with no skipped µs.
- Re-pressing the already-selected button reloads `target_reg` from `cmd`, cancelling any pending ramp.

## Test plan

Bench parameters: CLK_HZ=2_000_000 (US_DIV=2), FRAME_US=200, MIN_US=20, MAX_US=180, CENTER_US=100, STEP_US=10, NUM_SERVOS=4.

1. **Reset:** hold RST 3 cycles, release.
   - Required: `pwm[3:0]` high for exactly 200 CLK cycles, then low for 200 CLK cycles, repeating.
   - Required: `sel_onehot` = 4'b0001, `busy` = 0.
2. **Ramp:** `target_us` = 150 with `target_valid`.
   - Required: `busy` = 1 next cycle.
   - Required: `active_cmd` steps 110, 120, 130, 140, 150 on successive `frame_end`s, then `busy` = 0.
   - Required: `pwm[0]` high-times lag `active_cmd` by one frame.
   - Required: `pwm[3:1]` stay at 100 µs.
3. **Clamp and no overshoot:** `target_us` = 5.
   - Required: `target_reg` = 20.
   - Required: from `cmd` = 25 the next step lands on 20, not 15.
   - Then `target_us` = 1000: required `target_reg` = 180.
4. **Selection:** pulse `sel_btn[2]` mid-ramp on channel 0.
   - Required: `sel_onehot` = 4'b0100.
   - Required: channel 0 freezes at its current `cmd`.
   - Required: `busy` = 0, since `target_reg` = `cmd[2]` = 100.
   - Then `sel_btn` = 4'b1010 rising together: required channel 1 selected.
5. **Collision:** `target_valid` (`target_us` = 50) on the same cycle as a `sel_btn[3]` rising edge.
   - Required: channel 3 selected, `target_reg` = 100, no ramp.
6. **Mid-pulse reset:** assert RST while `pwm[0]` is high with `cmd[0]` = 150.
   - Required: `pwm` = 0 next cycle.
   - Required: all channels return to 100 µs pulses after release.
